// File: rtl/scan_sel_pkg.sv
// scan_sel_pkg: shared types and constants for the display select sequencer
//   state_t      FSM states IDLE/SCAN/SWEEP/DONE
//   DIR_UP/DOWN  encoding of the Dir input
//   SWEEP_STEPS  advances in one single sweep
//   step_sel     next select value for a given direction
package scan_sel_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, SWEEP, DONE} state_t;
    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DOWN = 1'b1;
    localparam int SWEEP_STEPS = 4;
    function automatic logic [1:0] step_sel(input logic [1:0] s, input logic d);
        return (d == DIR_DOWN) ? s - 2'd1 : s + 2'd1;
    endfunction
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: dwell prescaler counting 0..DIV_MAX
//   clk   in  clock
//   rst   in  synchronous active-high reset
//   clr   in  forces count to 0 (priority over en)
//   en    in  count enable
//   wrap  out high while count is at DIV_MAX (next enabled edge wraps to 0)
module scan_prescaler #(
    parameter int DIV_W = 16,
    parameter int DIV_MAX = 49999
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic wrap
);
    logic [DIV_W-1:0] cnt;
    assign wrap = cnt == DIV_W'(DIV_MAX);
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en) cnt <= wrap ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/scan_sel_gen.sv
// scan_sel_gen: timed 2-bit select sequencer for a 4-digit multiplexed display
//   Clk, Rst           clock, synchronous active-high reset
//   En                 count enable (0 freezes everything)
//   Free, Dir, Sweep   free-run mode, direction (0 up / 1 down), single-sweep request
//   I1, I0             registered select to the 2-to-4 decoder
//   Tick, Busy, Done   advance pulse, sweep in progress, sweep finished pulse
//   Blank              blank request, present only when SCAN_SEL_BLANK_EN is defined
module scan_sel_gen
    import scan_sel_pkg::*;
#(
    parameter int DIV_W = 16,
    parameter int DIV_MAX = 49999
`ifdef SCAN_SEL_BLANK_EN
    ,
    parameter int BLANK_CYC = 4
`endif
) (
    input  logic Clk,
    input  logic Rst,
    input  logic En,
    input  logic Free,
    input  logic Dir,
    input  logic Sweep,
    output logic I1,
    output logic I0,
    output logic Tick,
    output logic Busy,
    output logic Done
`ifdef SCAN_SEL_BLANK_EN
    ,
    output logic Blank
`endif
);
    state_t state, next;
    logic [1:0] sel, sel_d, step, step_d;
    logic dir_l, dir_d, wrap, active, adv;
    assign active = state == SCAN || state == SWEEP;
    // Dropping Free in SCAN wins over a coinciding wrap: no advance on exit
    assign adv = En && wrap && (state == SWEEP || (state == SCAN && Free));
    assign {I1, I0} = sel;
    scan_prescaler #(.DIV_W(DIV_W), .DIV_MAX(DIV_MAX)) u_pre (
        .clk (Clk),
        .rst (Rst),
        .clr (!active),
        .en  (En && active),
        .wrap(wrap)
    );
    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else state <= next;
    end
    always_comb begin
        next = state;
        if (En) begin
            case (state)
                IDLE:    next = Free ? SCAN : (Sweep ? SWEEP : IDLE);
                SCAN:    next = Free ? SCAN : IDLE;
                SWEEP:   next = (adv && step == 2'(SWEEP_STEPS - 1)) ? DONE : SWEEP;
                default: next = IDLE;
            endcase
        end
    end
    always_comb begin
        sel_d = sel;
        step_d = step;
        dir_d = dir_l;
        if (En && state == IDLE && next == SWEEP) begin
            sel_d = 2'b00;
            step_d = 2'd0;
            dir_d = Dir;
        end else if (adv) begin
            sel_d = step_sel(sel, state == SWEEP ? dir_l : Dir);
            step_d = step + 2'd1;
        end
    end
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sel <= 2'b00;
            step <= 2'd0;
            dir_l <= DIR_UP;
            Tick <= 1'b0;
            Busy <= 1'b0;
            Done <= 1'b0;
        end else begin
            sel <= sel_d;
            step <= step_d;
            dir_l <= dir_d;
            Tick <= adv;
            Busy <= next == SWEEP;
            Done <= En && state == DONE;
        end
    end
`ifdef SCAN_SEL_BLANK_EN
    logic [DIV_W-1:0] bcnt;
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Blank <= 1'b0;
            bcnt <= '0;
        end else if (En) begin
            if (next != SCAN && next != SWEEP) begin
                Blank <= 1'b0;
                bcnt <= '0;
            end else if (adv) begin
                Blank <= 1'b1;
                bcnt <= DIV_W'(BLANK_CYC - 1);
            end else if (bcnt != '0) begin
                bcnt <= bcnt - 1'b1;
            end else begin
                Blank <= 1'b0;
            end
        end
    end
`endif
endmodule
